// File: rtl/reg_read_pkg.sv
// Shared types, default sizes and operand-select helper for the register-read stage.
// Latency: none (declarations and a combinational function only).
// Backpressure: not applicable.
package reg_read_pkg;

  // Default architectural register count and operand width
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_REG_W    = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_REG_W-1:0] reg_idx_t;

  // Returns the operand for register idx. A writeback in flight to the same
  // register wins over the (not yet updated) register file contents.
  function automatic logic [DEF_DATA_W-1:0] operand_select(
    input logic [DEF_NUM_REGS*DEF_DATA_W-1:0] regfile,
    input reg_idx_t                           idx,
    input logic                               wb_valid,
    input reg_idx_t                           wb_idx,
    input logic [DEF_DATA_W-1:0]              wb_data
  );
    if (wb_valid && (wb_idx == idx)) begin
      return wb_data;
    end
    return regfile[int'(idx)*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register with an in-flight producer.
// Latency: set/clear visible on busy one cycle after the requesting edge.
// Backpressure: none; set wins over a same-cycle clear, flush wins over both.
module reg_scoreboard
  import reg_read_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int REG_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          set_vld,
  input  logic [2*REG_W-1:0]  set_idx,
  input  logic                clr_vld,
  input  logic [REG_W-1:0]    clr_idx,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  // Decode set and clear requests into one-hot masks; both destinations
  // naming the same register simply OR into a single bit.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    for (int k = 0; k < 2; k++) begin
      if (set_vld[k]) begin
        w_set_mask[set_idx[k*REG_W +: REG_W]] = 1'b1;
      end
    end
    if (clr_vld) begin
      w_clr_mask[clr_idx] = 1'b1;
    end
  end

  // Clear is applied before set so a younger producer keeps its bit when an
  // older writeback to the same register lands in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  assign busy = r_busy;

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: reads source operands, stalls on RAW hazards, registers the decoded bundle.
// Latency: 1 cycle from fire to out_valid.
// Backpressure: valid/ready both sides; output held while out_valid && !out_ready. Macro REG_READ_BYPASS_EN enables writeback bypass.
module reg_read_stage
  import reg_read_pkg::*;
#(
  parameter  int NUM_REGS  = DEF_NUM_REGS,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int NUM_SRC   = 2,
  parameter  int PAYLOAD_W = 256,
  localparam int REG_W     = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_SRC*REG_W-1:0]   src_idx,
  input  logic [NUM_SRC-1:0]         src_vld,
  input  logic [2*REG_W-1:0]         dst_idx,
  input  logic [1:0]                 dst_vld,
  input  logic [PAYLOAD_W-1:0]       payload_in,
  input  logic [NUM_REGS*DATA_W-1:0] regfile,
  input  logic                       wb_valid,
  input  logic [REG_W-1:0]           wb_idx,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_SRC*DATA_W-1:0]  opnd_out,
  output logic [NUM_SRC-1:0]         opnd_vld,
  output logic [2*REG_W-1:0]         dst_idx_out,
  output logic [1:0]                 dst_vld_out,
  output logic [PAYLOAD_W-1:0]       payload_out
);

  logic [NUM_REGS-1:0]       w_busy;
  logic [NUM_SRC-1:0]        w_src_haz;
  logic [NUM_SRC*DATA_W-1:0] w_opnd;
  logic                      w_byp_vld;
  logic                      w_hazard;
  logic                      w_fire;

  logic                      r_out_valid;
  logic [NUM_SRC*DATA_W-1:0] r_opnd;
  logic [NUM_SRC-1:0]        r_opnd_vld;
  logic [2*REG_W-1:0]        r_dst_idx;
  logic [1:0]                r_dst_vld;
  logic [PAYLOAD_W-1:0]      r_payload;

`ifdef REG_READ_BYPASS_EN
  // A writeback landing this cycle is forwarded straight into the operand.
  assign w_byp_vld = wb_valid;
`else
  // Without forwarding, a dependent source waits for its busy bit to drop
  // and then reads the already-updated register file.
  assign w_byp_vld = 1'b0;
`endif

  // Per-source operand select and hazard detection
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_W-1:0]  w_idx;
    logic              w_byp_hit;
    logic [DATA_W-1:0] w_val;

    assign w_idx     = src_idx[i*REG_W +: REG_W];
    assign w_byp_hit = w_byp_vld && (wb_idx == w_idx);

    // Hazard uses the pre-fire scoreboard, so a source equal to the same
    // instruction's destination never stalls itself.
    assign w_src_haz[i] = src_vld[i] && w_busy[w_idx] && !w_byp_hit;

    if ((NUM_REGS == DEF_NUM_REGS) && (DATA_W == DEF_DATA_W)) begin : g_pkg_sel
      assign w_val = operand_select(regfile, w_idx, w_byp_vld, wb_idx, wb_data);
    end else begin : g_gen_sel
      assign w_val = w_byp_hit ? wb_data : regfile[int'(w_idx)*DATA_W +: DATA_W];
    end

    assign w_opnd[i*DATA_W +: DATA_W] = src_vld[i] ? w_val : '0;
  end

  assign w_hazard = |w_src_haz;
  assign in_ready = !w_hazard && (!r_out_valid || out_ready) && !flush;
  assign w_fire   = in_valid && in_ready;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_vld (dst_vld & {2{w_fire}}),
    .set_idx (dst_idx),
    .clr_vld (wb_valid),
    .clr_idx (wb_idx),
    .flush   (flush),
    .busy    (w_busy)
  );

  // Output pipeline register: load on fire, hold under backpressure,
  // drop valid on accept or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_opnd      <= '0;
      r_opnd_vld  <= '0;
      r_dst_idx   <= '0;
      r_dst_vld   <= '0;
      r_payload   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_opnd      <= w_opnd;
      r_opnd_vld  <= src_vld;
      r_dst_idx   <= dst_idx;
      r_dst_vld   <= dst_vld;
      r_payload   <= payload_in;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign opnd_out    = r_opnd;
  assign opnd_vld    = r_opnd_vld;
  assign dst_idx_out = r_dst_idx;
  assign dst_vld_out = r_dst_vld;
  assign payload_out = r_payload;

endmodule

// File: tb/tb_reg_read_stage.sv
// Testbench for reg_read_stage: directed scenarios plus randomized traffic against a reference model.
// Latency: expects operands one cycle after fire.
// Backpressure: exercises out_ready stalls, RAW stalls and flush; honours REG_READ_BYPASS_EN.
module tb_reg_read_stage;

  localparam int NR = 16;
  localparam int DW = 64;
  localparam int NS = 2;
  localparam int PW = 256;
  localparam int RW = 4;

`ifdef REG_READ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [NS*RW-1:0] src_idx;
  logic [NS-1:0]    src_vld;
  logic [2*RW-1:0]  dst_idx;
  logic [1:0]       dst_vld;
  logic [PW-1:0]    payload_in;
  logic [NR*DW-1:0] regfile;
  logic             wb_valid;
  logic [RW-1:0]    wb_idx;
  logic [DW-1:0]    wb_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [NS*DW-1:0] opnd_out;
  logic [NS-1:0]    opnd_vld;
  logic [2*RW-1:0]  dst_idx_out;
  logic [1:0]       dst_vld_out;
  logic [PW-1:0]    payload_out;

  logic [DW-1:0] rf [NR];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [NR-1:0]    m_sb;
  logic             m_ov;
  logic [NS*DW-1:0] m_opnd;
  logic [NS-1:0]    m_ovld;
  logic [2*RW-1:0]  m_didx;
  logic [1:0]       m_dvld;
  logic [PW-1:0]    m_pay;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NR; k++) regfile[k*DW +: DW] = rf[k];
  end

  reg_read_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src_idx     (src_idx),
    .src_vld     (src_vld),
    .dst_idx     (dst_idx),
    .dst_vld     (dst_vld),
    .payload_in  (payload_in),
    .regfile     (regfile),
    .wb_valid    (wb_valid),
    .wb_idx      (wb_idx),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opnd_out    (opnd_out),
    .opnd_vld    (opnd_vld),
    .dst_idx_out (dst_idx_out),
    .dst_vld_out (dst_vld_out),
    .payload_out (payload_out)
  );

  function automatic logic [DW-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    logic [PW-1:0] p;
    for (int k = 0; k < PW/32; k++) p[k*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    src_idx    = '0;
    src_vld    = '0;
    dst_idx    = '0;
    dst_vld    = '0;
    payload_in = '0;
    wb_valid   = 1'b0;
    wb_idx     = '0;
    wb_data    = '0;
    flush      = 1'b0;
    out_ready  = 1'b1;
  endtask

  task automatic m_reset();
    m_sb = '0; m_ov = 1'b0; m_opnd = '0; m_ovld = '0; m_didx = '0; m_dvld = '0; m_pay = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_reset();
  endtask

  // A source can issue when its register has no in-flight producer, or
  // (with forwarding) when that producer's writeback is arriving right now.
  function automatic bit m_ready();
    bit haz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      logic [RW-1:0] s = src_idx[i*RW +: RW];
      if (src_vld[i] && m_sb[s] && !(BYP && wb_valid && wb_idx == s)) haz = 1'b1;
    end
    return !haz && (!m_ov || out_ready) && !flush;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic m_edge();
    bit fire = in_valid && m_ready();
    if (flush) begin
      m_ov = 1'b0;
      m_sb = '0;
    end else begin
      if (fire) begin
        for (int i = 0; i < NS; i++) begin
          logic [RW-1:0] s = src_idx[i*RW +: RW];
          if (!src_vld[i])                       m_opnd[i*DW +: DW] = '0;
          else if (BYP && wb_valid && wb_idx == s) m_opnd[i*DW +: DW] = wb_data;
          else                                   m_opnd[i*DW +: DW] = rf[s];
        end
        m_ov = 1'b1; m_ovld = src_vld; m_didx = dst_idx; m_dvld = dst_vld; m_pay = payload_in;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (wb_valid) m_sb[wb_idx] = 1'b0;
      if (fire) begin
        for (int k = 0; k < 2; k++) if (dst_vld[k]) m_sb[dst_idx[k*RW +: RW]] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    idle();
    in_valid = 1'b1; src_vld = 2'b11; payload_in = rand_payload(); out_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    idle();
    reset = 1'b0;
    m_reset();
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    n_tests++; if (dut.w_busy !== 16'h0) begin n_fail++; $display("FAIL reset_sb got=%0h exp=0", dut.w_busy); end
    n_tests++; if (opnd_out !== '0 || opnd_vld !== 2'b00 || dst_vld_out !== 2'b00) begin
      n_fail++; $display("FAIL reset_opnd opnd=%0h vld=%0h dvld=%0h exp=0", opnd_out, opnd_vld, dst_vld_out); end
    n_tests++; if (payload_out !== '0) begin n_fail++; $display("FAIL reset_payload got=%0h exp=0", payload_out); end
  endtask

  task automatic test_basic_read();
    logic [PW-1:0] p;
    do_reset();
    rf[3] = 64'h55; rf[5] = 64'h7;
    p = rand_payload();
    in_valid = 1'b1; src_idx = {4'd5, 4'd3}; src_vld = 2'b11; payload_in = p;
    dst_idx = {4'd0, 4'd9}; dst_vld = 2'b00;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got=%0h exp=1", out_valid); end
    n_tests++; if (opnd_out !== {64'h7, 64'h55}) begin n_fail++; $display("FAIL basic_opnd got=%0h exp=%0h", opnd_out, {64'h7, 64'h55}); end
    n_tests++; if (opnd_vld !== 2'b11) begin n_fail++; $display("FAIL basic_opnd_vld got=%0h exp=3", opnd_vld); end
    n_tests++; if (payload_out !== p) begin n_fail++; $display("FAIL basic_payload got=%0h exp=%0h", payload_out, p); end
    n_tests++; if (dst_idx_out !== 8'h09 || dst_vld_out !== 2'b00) begin
      n_fail++; $display("FAIL basic_dst got=%0h/%0h exp=09/0", dst_idx_out, dst_vld_out); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop got=%0h exp=0", out_valid); end
    // Only source 0 valid: source 1 operand must read as zero.
    in_valid = 1'b1; src_vld = 2'b01;
    tick();
    in_valid = 1'b0;
    n_tests++; if (opnd_out !== {64'h0, 64'h55} || opnd_vld !== 2'b01) begin
      n_fail++; $display("FAIL partial_src got=%0h vld=%0h exp=%0h vld=1", opnd_out, opnd_vld, {64'h0, 64'h55}); end
    tick();
  endtask

  task automatic test_raw_stall();
    int lat;
    logic [PW-1:0] pb;
    do_reset();
    // A writes r2
    in_valid = 1'b1; dst_idx = {4'd0, 4'd2}; dst_vld = 2'b01; src_vld = 2'b00;
    tick();
    // B reads r2
    pb = rand_payload();
    src_idx = {4'd0, 4'd2}; src_vld = 2'b01; dst_vld = 2'b00; payload_in = pb;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall got=%0h exp=0", in_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_no_issue got=%0h exp=0", out_valid); end
    wb_valid = 1'b1; wb_idx = 4'd2; wb_data = 64'hAB;
    #1;
    n_tests++; if (in_ready !== BYP) begin n_fail++; $display("FAIL raw_wb_ready got=%0h exp=%0h", in_ready, BYP); end
    tick();
    rf[2] = 64'hAB; wb_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 4) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    n_tests++; if (lat != (BYP ? 1 : 2)) begin n_fail++; $display("FAIL raw_latency got=%0d exp=%0d", lat, BYP ? 1 : 2); end
    n_tests++; if (opnd_out[63:0] !== 64'hAB || payload_out !== pb) begin
      n_fail++; $display("FAIL raw_opnd got=%0h exp=ab", opnd_out[63:0]); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] px, py;
    logic [NS*DW-1:0] ex;
    do_reset();
    px = rand_payload(); py = rand_payload();
    rf[1] = rand64(); rf[6] = rand64();
    ex = {64'h0, rf[1]};
    in_valid = 1'b1; src_idx = {4'd0, 4'd1}; src_vld = 2'b01; payload_in = px; out_ready = 1'b0;
    tick();
    src_idx = {4'd0, 4'd6}; payload_in = py;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%0h exp=0", c, in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b1 || opnd_out !== ex || payload_out !== px) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d valid=%0h opnd=%0h exp opnd=%0h", c, out_valid, opnd_out, ex); end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || opnd_out !== {64'h0, rf[6]} || payload_out !== py) begin
      n_fail++; $display("FAIL bp_next valid=%0h opnd=%0h exp=%0h", out_valid, opnd_out, {64'h0, rf[6]}); end
    tick();
  endtask

  task automatic test_sb_set_clear();
    do_reset();
    in_valid = 1'b1; dst_idx = {4'd0, 4'd4}; dst_vld = 2'b01;
    wb_valid = 1'b1; wb_idx = 4'd4; wb_data = 64'h1234;
    tick();
    rf[4] = 64'h1234; wb_valid = 1'b0;
    n_tests++; if (dut.w_busy !== 16'h0010) begin n_fail++; $display("FAIL sb_set_wins got=%0h exp=0010", dut.w_busy); end
    dst_idx = {4'd2, 4'd0}; dst_vld = 2'b11;
    tick();
    n_tests++; if (dut.w_busy !== 16'h0015) begin n_fail++; $display("FAIL sb_imul got=%0h exp=0015", dut.w_busy); end
    dst_idx = {4'd9, 4'd9};
    tick();
    n_tests++; if (dut.w_busy !== 16'h0215) begin n_fail++; $display("FAIL sb_same_dst got=%0h exp=0215", dut.w_busy); end
    in_valid = 1'b0; wb_valid = 1'b1; wb_idx = 4'd11;
    tick();
    n_tests++; if (dut.w_busy !== 16'h0215) begin n_fail++; $display("FAIL sb_wb_clear_bit got=%0h exp=0215", dut.w_busy); end
    wb_idx = 4'd4;
    tick();
    wb_valid = 1'b0;
    n_tests++; if (dut.w_busy !== 16'h0205) begin n_fail++; $display("FAIL sb_wb_clr got=%0h exp=0205", dut.w_busy); end
    // Source equal to own destination on a free register must not stall.
    in_valid = 1'b1; src_idx = {4'd0, 4'd7}; src_vld = 2'b01; dst_idx = {4'd0, 4'd7}; dst_vld = 2'b01;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sb_self_src got=%0h exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_tests++; if (dut.w_busy !== 16'h0285) begin n_fail++; $display("FAIL sb_self_set got=%0h exp=0285", dut.w_busy); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; dst_idx = {4'd7, 4'd1}; dst_vld = 2'b11; out_ready = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b1 || dut.w_busy !== 16'h0082) begin
      n_fail++; $display("FAIL flush_setup valid=%0h sb=%0h exp valid=1 sb=0082", out_valid, dut.w_busy); end
    dst_idx = {4'd3, 4'd5}; flush = 1'b1;
    wb_valid = 1'b1; wb_idx = 4'd1; wb_data = 64'hF00D;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    tick();
    rf[1] = 64'hF00D;
    idle();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%0h exp=0", out_valid); end
    n_tests++; if (dut.w_busy !== 16'h0) begin n_fail++; $display("FAIL flush_sb got=%0h exp=0", dut.w_busy); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    in_valid = 1'b1; dst_idx = {4'd0, 4'd3}; dst_vld = 2'b01; src_vld = 2'b00; out_ready = 1'b0;
    payload_in = rand_payload();
    tick();
    src_idx = {4'd0, 4'd3}; src_vld = 2'b01; dst_vld = 2'b00;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_stall got=%0h exp=0", in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    m_reset();
    n_tests++; if (out_valid !== 1'b0 || opnd_out !== '0 || payload_out !== '0 || dst_vld_out !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_out valid=%0h payload=%0h exp=0", out_valid, payload_out); end
    n_tests++; if (dut.w_busy !== 16'h0) begin n_fail++; $display("FAIL mid_reset_sb got=%0h exp=0", dut.w_busy); end
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      src_idx    = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      src_vld    = 2'($urandom_range(0, 3));
      dst_idx    = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      dst_vld    = 2'($urandom_range(0, 3));
      payload_in = rand_payload();
      wb_valid   = ($urandom_range(0, 9) < 4);
      wb_idx     = 4'($urandom_range(0, 7));
      wb_data    = rand64();
      flush      = ($urandom_range(0, 99) < 3);
      out_ready  = ($urandom_range(0, 99) < 65);
      #1;
      exp_rdy = m_ready();
      n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%0h exp=%0h", c, in_ready, exp_rdy); end
      m_edge();
      tick();
      if (wb_valid) rf[wb_idx] = wb_data;
      n_tests++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_out_valid cyc=%0d got=%0h exp=%0h", c, out_valid, m_ov); end
      n_tests++; if (dut.w_busy !== m_sb) begin n_fail++; $display("FAIL rnd_sb cyc=%0d got=%0h exp=%0h", c, dut.w_busy, m_sb); end
      if (m_ov) begin
        n_tests++;
        if (opnd_out !== m_opnd || opnd_vld !== m_ovld || dst_idx_out !== m_didx || dst_vld_out !== m_dvld || payload_out !== m_pay) begin
          n_fail++; $display("FAIL rnd_data cyc=%0d opnd=%0h exp=%0h vld=%0h exp=%0h dst=%0h/%0h exp=%0h/%0h",
                             c, opnd_out, m_opnd, opnd_vld, m_ovld, dst_idx_out, dst_vld_out, m_didx, m_dvld);
        end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    for (int k = 0; k < NR; k++) rf[k] = rand64();
    m_reset();
    test_reset();
    test_basic_read();
    test_raw_stall();
    test_backpressure();
    test_sb_set_clear();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
